rr_fifo_arbiter: RTL and testbench



---
 rtl/arb_pkg.sv | 13 +
 rtl/rr_pick.sv | 31 +++
 rtl/rr_fifo_arbiter.sv | 153 +++++++++++++++
 tb/tb_rr_fifo_arbiter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin fifo arbiter and its neighbours:
// FSM state encoding and the default geometry shared with the fifo.
package arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    localparam int ARB_NUM_REQ       = 4;
    localparam int ARB_ELE_BANDWIDTH = 8;

endpackage

// File: rtl/rr_pick.sv
// Combinational circular first-one finder: scans the request vector from
// prio_ptr upward, wrapping NUM_REQ-1 to 0, and reports the first set bit.
// Works for any NUM_REQ, power of two or not.
module rr_pick
    import arb_pkg::*;
#(
    parameter int NUM_REQ = ARB_NUM_REQ,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   prio_ptr,
    output logic               found,
    output logic [PTR_W-1:0]   index
);

    // Walk the ring starting at prio_ptr and keep the first hit only.
    always_comb begin
        int pos;
        pos   = 0;
        found = 1'b0;
        index = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pos = (int'(prio_ptr) + i) % NUM_REQ;
            if (!found && req[pos[PTR_W-1:0]]) begin
                found = 1'b1;
                index = pos[PTR_W-1:0];
            end
        end
    end

endmodule

// File: rtl/rr_fifo_arbiter.sv
// Round-robin, burst-locked arbiter sharing one fifo push port between
// NUM_REQ requesters. The owner keeps the port until it transfers a beat
// flagged last; priority then rotates to the requester after the owner.
// The data path is a pure pass-through of the owner: nothing is stored.
// Optional build macro ARB_BURST_LIMIT_EN: also release after MAX_BURST beats.
module rr_fifo_arbiter
    import arb_pkg::*;
#(
    parameter int NUM_REQ           = ARB_NUM_REQ,
    parameter int REQ_PTR_BANDWIDTH = $clog2(NUM_REQ),
    parameter int ELE_BANDWIDTH     = ARB_ELE_BANDWIDTH,
    parameter int MAX_BURST         = 16
) (
    input  logic                               i_clk,
    input  logic                               i_rst,
    input  logic [NUM_REQ-1:0]                 i_req_valid,
    input  logic [NUM_REQ-1:0]                 i_req_last,
    input  logic [NUM_REQ*ELE_BANDWIDTH-1:0]   i_req_data,
    output logic [NUM_REQ-1:0]                 o_req_ready,
    output logic                               o_valid,
    output logic [ELE_BANDWIDTH-1:0]           o_data,
    input  logic                               i_ready,
    output logic [REQ_PTR_BANDWIDTH-1:0]       o_grant_id,
    output logic                               o_busy
);

    if (NUM_REQ < 2 || NUM_REQ > 16 || REQ_PTR_BANDWIDTH != $clog2(NUM_REQ) ||
        MAX_BURST < 1) begin : g_bad_params
        $error("rr_fifo_arbiter: illegal parameter combination");
    end

    arb_state_t                   state, state_next;
    logic [REQ_PTR_BANDWIDTH-1:0] prio_ptr, prio_next;
    logic [REQ_PTR_BANDWIDTH-1:0] grant_id, grant_next;
    logic [REQ_PTR_BANDWIDTH-1:0] after_owner;
    logic                         pick_found;
    logic [REQ_PTR_BANDWIDTH-1:0] pick_index;
    logic                         owner_valid;
    logic                         owner_last;
    logic [ELE_BANDWIDTH-1:0]     owner_data;
    logic                         beat;
    logic                         limit_hit;
    logic                         release_burst;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (REQ_PTR_BANDWIDTH)
    ) u_pick (
        .req      (i_req_valid),
        .prio_ptr (prio_ptr),
        .found    (pick_found),
        .index    (pick_index)
    );

    // Select the current owner's valid/last/data lanes.
    always_comb begin
        owner_valid = 1'b0;
        owner_last  = 1'b0;
        owner_data  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant_id == REQ_PTR_BANDWIDTH'(k)) begin
                owner_valid = i_req_valid[k];
                owner_last  = i_req_last[k];
                owner_data  = i_req_data[k*ELE_BANDWIDTH +: ELE_BANDWIDTH];
            end
        end
    end

    // Priority after a release points just past the owner; explicit wrap
    // because NUM_REQ need not be a power of two.
    assign after_owner = (grant_id == REQ_PTR_BANDWIDTH'(NUM_REQ - 1)) ?
                         '0 : grant_id + REQ_PTR_BANDWIDTH'(1);

    assign beat = (state == ARB_GRANT) && owner_valid && i_ready;

`ifdef ARB_BURST_LIMIT_EN
    localparam int BEAT_W = $clog2(MAX_BURST) + 1;

    logic [BEAT_W-1:0] beat_cnt, beat_cnt_next;

    assign limit_hit = (beat_cnt == BEAT_W'(MAX_BURST - 1));

    // Beats already moved in this grant; cleared when a new grant starts.
    always_comb begin
        beat_cnt_next = beat_cnt;
        if (state == ARB_IDLE && pick_found) begin
            beat_cnt_next = '0;
        end else if (beat) begin
            beat_cnt_next = beat_cnt + BEAT_W'(1);
        end
    end

    // Beat counter register.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            beat_cnt <= '0;
        end else begin
            beat_cnt <= beat_cnt_next;
        end
    end
`else
    assign limit_hit = 1'b0;
`endif

    assign release_burst = beat && (owner_last || limit_hit);

    // Next-state logic and the owner pass-through / ready demux.
    always_comb begin
        state_next  = state;
        grant_next  = grant_id;
        prio_next   = prio_ptr;
        o_valid     = 1'b0;
        o_data      = '0;
        o_req_ready = '0;
        case (state)
            ARB_IDLE: begin
                if (pick_found) begin
                    grant_next = pick_index;
                    state_next = ARB_GRANT;
                end
            end
            ARB_GRANT: begin
                o_valid = owner_valid;
                o_data  = owner_data;
                for (int k = 0; k < NUM_REQ; k++) begin
                    o_req_ready[k] = i_ready && (grant_id == REQ_PTR_BANDWIDTH'(k));
                end
                if (release_burst) begin
                    state_next = ARB_IDLE;
                    prio_next  = after_owner;
                end
            end
            default: state_next = ARB_IDLE;
        endcase
    end

    // State, owner and priority registers.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state    <= ARB_IDLE;
            grant_id <= '0;
            prio_ptr <= '0;
        end else begin
            state    <= state_next;
            grant_id <= grant_next;
            prio_ptr <= prio_next;
        end
    end

    assign o_busy     = (state == ARB_GRANT);
    assign o_grant_id = grant_id;

endmodule

// File: tb/tb_rr_fifo_arbiter.sv
// Bench for rr_fifo_arbiter (4 requesters, 8-bit elements, MAX_BURST=4).
// Per-cycle vectors in a table plus hand-written multi-cycle sequences;
// every accepted beat is matched against a scoreboard of expected beats.
module tb_rr_fifo_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  i_req_valid;
    logic [3:0]  i_req_last;
    logic [31:0] i_req_data;
    logic [3:0]  o_req_ready;
    logic        o_valid;
    logic [7:0]  o_data;
    logic        i_ready;
    logic [1:0]  o_grant_id;
    logic        o_busy;

    int n_checks = 0;
    int n_errors = 0;
    int n_pushed = 0;
    int n_beats  = 0;

    logic [9:0] sb[$];

    typedef struct {
        logic [3:0]  valid;
        logic [3:0]  last;
        logic [31:0] data;
        logic        rdy;
        logic        e_valid;
        logic [3:0]  e_rdy;
        logic        e_busy;
        logic [1:0]  e_gid;
        logic [7:0]  e_data;
    } vec_t;

    vec_t vecs[$];

`ifdef ARB_BURST_LIMIT_EN
    localparam int         F_BEATS = 4;
    localparam logic [3:0] F_AFTER = 4'b0011;
`else
    localparam int         F_BEATS = 10;
    localparam logic [3:0] F_AFTER = 4'b0010;
`endif

    rr_fifo_arbiter #(
        .NUM_REQ           (4),
        .REQ_PTR_BANDWIDTH (2),
        .ELE_BANDWIDTH     (8),
        .MAX_BURST         (4)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst_n),
        .i_req_valid (i_req_valid),
        .i_req_last  (i_req_last),
        .i_req_data  (i_req_data),
        .o_req_ready (o_req_ready),
        .o_valid     (o_valid),
        .o_data      (o_data),
        .i_ready     (i_ready),
        .o_grant_id  (o_grant_id),
        .o_busy      (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] lane(input int k, input logic [7:0] b);
        return {24'h0, b} << (8 * k);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic ev, input logic [3:0] erdy,
                              input logic ebusy, input logic [1:0] egid, input logic [7:0] edata);
        chk({tag, ".valid"}, {31'h0, o_valid}, {31'h0, ev});
        chk({tag, ".ready"}, {28'h0, o_req_ready}, {28'h0, erdy});
        chk({tag, ".busy"}, {31'h0, o_busy}, {31'h0, ebusy});
        chk({tag, ".gid"}, {30'h0, o_grant_id}, {30'h0, egid});
        chk({tag, ".data"}, {24'h0, o_data}, {24'h0, edata});
    endtask

    task automatic drive(input logic [3:0] v, input logic [3:0] l, input logic [31:0] d, input logic r);
        @(posedge clk);
        #1;
        i_req_valid = v;
        i_req_last  = l;
        i_req_data  = d;
        i_ready     = r;
        #2;
    endtask

    task automatic push_beat(input logic [1:0] g, input logic [7:0] d);
        sb.push_back({g, d});
        n_pushed++;
    endtask

    task automatic add_vec(input logic [3:0] v, input logic [3:0] l, input logic [31:0] d, input logic r,
                           input logic ev, input logic [3:0] erdy, input logic ebusy,
                           input logic [1:0] egid, input logic [7:0] edata);
        vec_t x;
        x.valid = v; x.last = l; x.data = d; x.rdy = r;
        x.e_valid = ev; x.e_rdy = erdy; x.e_busy = ebusy; x.e_gid = egid; x.e_data = edata;
        vecs.push_back(x);
    endtask

    // Fifo side: each accepted beat must be the next expected one.
    always @(negedge clk) begin
        if (rst_n && o_valid && i_ready) begin
            n_beats++;
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_beat: got id %0d data %0h required no beat", o_grant_id, o_data);
            end else begin
                chk("beat", {22'h0, o_grant_id, o_data}, {22'h0, sb.pop_front()});
            end
        end
    end

    initial begin
        logic [31:0] dall;
        int          prev;

        // Reset with requests present: all outputs must stay low.
        rst_n       = 1'b0;
        i_req_valid = 4'b1111;
        i_req_last  = 4'b0000;
        i_req_data  = 32'hdead_beef;
        i_ready     = 1'b1;
        #3;
        expect_out("reset", 1'b0, 4'b0, 1'b0, 2'd0, 8'h00);
        i_req_valid = 4'b0000;
        i_req_data  = 32'h0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Idle for five cycles.
        for (int i = 0; i < 5; i++) add_vec(4'b0000, 4'b0000, 32'h0, 1'b1, 1'b0, 4'b0, 1'b0, 2'd0, 8'h00);

        // Requesters 1 and 3, prio 0: requester 1 wins, 3-beat burst, then 3.
        add_vec(4'b1010, 4'b0000, lane(1, 8'h11) | lane(3, 8'h31), 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0, 8'h00);
        add_vec(4'b1010, 4'b0000, lane(1, 8'h11) | lane(3, 8'h31), 1'b1, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h11);
        add_vec(4'b1010, 4'b0000, lane(1, 8'h12) | lane(3, 8'h31), 1'b1, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h12);
        add_vec(4'b1010, 4'b0010, lane(1, 8'h13) | lane(3, 8'h31), 1'b1, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h13);
        add_vec(4'b1000, 4'b0000, lane(3, 8'h31), 1'b1, 1'b0, 4'b0000, 1'b0, 2'd1, 8'h00);
        add_vec(4'b1000, 4'b1000, lane(3, 8'h31), 1'b1, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h31);
        add_vec(4'b0000, 4'b0000, 32'h0, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd3, 8'h00);

        // All four valid with single-beat bursts: 0,1,2,3,0 with a bubble each.
        dall = 32'hA3A2_A1A0;
        prev = 3;
        for (int g = 0; g < 5; g++) begin
            add_vec(4'b1111, 4'b1111, dall, 1'b1, 1'b0, 4'b0000, 1'b0, 2'(prev), 8'h00);
            add_vec(4'b1111, 4'b1111, dall, 1'b1, 1'b1, 4'b0001 << (g % 4), 1'b1, 2'(g % 4),
                    8'hA0 + 8'(g % 4));
            prev = g % 4;
        end
        add_vec(4'b0000, 4'b0000, 32'h0, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0, 8'h00);

        foreach (vecs[i]) begin
            drive(vecs[i].valid, vecs[i].last, vecs[i].data, vecs[i].rdy);
            expect_out($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_rdy, vecs[i].e_busy,
                       vecs[i].e_gid, vecs[i].e_data);
            if (vecs[i].e_valid && vecs[i].rdy) push_beat(vecs[i].e_gid, vecs[i].e_data);
        end

        // Requester 2 burst with the fifo full for 4 cycles on beat 2.
        drive(4'b0100, 4'b0000, lane(2, 8'h21), 1'b1);
        expect_out("stall.arb", 1'b0, 4'b0000, 1'b0, 2'd0, 8'h00);
        for (int b = 0; b < 4; b++) begin
            if (b == 1) begin
                for (int s = 0; s < 4; s++) begin
                    drive(4'b0100, 4'b0000, lane(2, 8'h22), 1'b0);
                    expect_out($sformatf("stall.hold%0d", s), 1'b1, 4'b0000, 1'b1, 2'd2, 8'h22);
                end
            end
            drive(4'b0100, (b == 3) ? 4'b0100 : 4'b0000, lane(2, 8'h21 + 8'(b)), 1'b1);
            expect_out($sformatf("stall.beat%0d", b), 1'b1, 4'b0100, 1'b1, 2'd2, 8'h21 + 8'(b));
            push_beat(2'd2, 8'h21 + 8'(b));
        end
        drive(4'b0000, 4'b0000, 32'h0, 1'b1);
        expect_out("stall.done", 1'b0, 4'b0000, 1'b0, 2'd2, 8'h00);

        // Reset during beat 2 of a 5-beat burst from requester 0 (prio is 3 here).
        drive(4'b0001, 4'b0000, lane(0, 8'h01), 1'b1);
        expect_out("rst.arb", 1'b0, 4'b0000, 1'b0, 2'd2, 8'h00);
        drive(4'b0001, 4'b0000, lane(0, 8'h01), 1'b1);
        expect_out("rst.beat1", 1'b1, 4'b0001, 1'b1, 2'd0, 8'h01);
        push_beat(2'd0, 8'h01);
        @(posedge clk);
        #1;
        i_req_data = lane(0, 8'h02);
        #1;
        rst_n = 1'b0;
        #1;
        expect_out("rst.async", 1'b0, 4'b0000, 1'b0, 2'd0, 8'h00);
        @(posedge clk);
        #1;
        expect_out("rst.held", 1'b0, 4'b0000, 1'b0, 2'd0, 8'h00);
        @(posedge clk);
        #1;
        rst_n       = 1'b1;
        i_req_valid = 4'b1001;
        i_req_last  = 4'b1001;
        i_req_data  = lane(0, 8'h0A) | lane(3, 8'h3A);
        #2;
        expect_out("rst.idle", 1'b0, 4'b0000, 1'b0, 2'd0, 8'h00);
        // Priority back at 0: requester 0 beats requester 3.
        drive(4'b1001, 4'b1001, lane(0, 8'h0A) | lane(3, 8'h3A), 1'b1);
        expect_out("rst.prio0", 1'b1, 4'b0001, 1'b1, 2'd0, 8'h0A);
        push_beat(2'd0, 8'h0A);
        drive(4'b1000, 4'b1000, lane(3, 8'h3A), 1'b1);
        expect_out("rst.gap", 1'b0, 4'b0000, 1'b0, 2'd0, 8'h00);
        drive(4'b1000, 4'b1000, lane(3, 8'h3A), 1'b1);
        expect_out("rst.next3", 1'b1, 4'b1000, 1'b1, 2'd3, 8'h3A);
        push_beat(2'd3, 8'h3A);
        drive(4'b0000, 4'b0000, 32'h0, 1'b1);
        expect_out("rst.end", 1'b0, 4'b0000, 1'b0, 2'd3, 8'h00);

        // Long burst from requester 0 while requester 1 waits (prio moved to 2 first).
        drive(4'b0010, 4'b0010, lane(1, 8'h1F), 1'b1);
        expect_out("lim.pre_arb", 1'b0, 4'b0000, 1'b0, 2'd3, 8'h00);
        drive(4'b0010, 4'b0010, lane(1, 8'h1F), 1'b1);
        expect_out("lim.pre", 1'b1, 4'b0010, 1'b1, 2'd1, 8'h1F);
        push_beat(2'd1, 8'h1F);
        drive(4'b0011, 4'b0000, lane(0, 8'h40) | lane(1, 8'h50), 1'b1);
        expect_out("lim.arb", 1'b0, 4'b0000, 1'b0, 2'd1, 8'h00);
        for (int i = 0; i < F_BEATS; i++) begin
`ifdef ARB_BURST_LIMIT_EN
            drive(4'b0011, 4'b0000, lane(0, 8'h40 + 8'(i)) | lane(1, 8'h50), 1'b1);
`else
            drive(4'b0011, (i == 9) ? 4'b0001 : 4'b0000, lane(0, 8'h40 + 8'(i)) | lane(1, 8'h50), 1'b1);
`endif
            expect_out($sformatf("lim.beat%0d", i), 1'b1, 4'b0001, 1'b1, 2'd0, 8'h40 + 8'(i));
            push_beat(2'd0, 8'h40 + 8'(i));
        end
        drive(F_AFTER, 4'b0000, lane(0, 8'h40 + 8'(F_BEATS)) | lane(1, 8'h50), 1'b1);
        expect_out("lim.release", 1'b0, 4'b0000, 1'b0, 2'd0, 8'h00);
        drive(F_AFTER, 4'b0010, lane(0, 8'h40 + 8'(F_BEATS)) | lane(1, 8'h50), 1'b1);
        expect_out("lim.next1", 1'b1, 4'b0010, 1'b1, 2'd1, 8'h50);
        push_beat(2'd1, 8'h50);
        drive(4'b0000, 4'b0000, 32'h0, 1'b1);
        expect_out("lim.end", 1'b0, 4'b0000, 1'b0, 2'd1, 8'h00);

        @(posedge clk);
        #1;
        chk("sb_left", sb.size(), 32'd0);
        chk("beat_count", n_beats, n_pushed);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
